// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the conv2 window read scheduler.
package conv_pkg;

   // Default geometry of the conv1 output map and the conv2 window
   localparam int DEF_MAP_W     = 12;
   localparam int DEF_MAP_H     = 12;
   localparam int DEF_K         = 5;
   localparam int DEF_ADDR_STEP = 6;
   localparam int DEF_ADDR_W    = 10;
   localparam int DEF_BASE      = 0;

   // Window counts and beats per frame for the default geometry
   localparam int N_WIN_X = DEF_MAP_W - DEF_K + 1;
   localparam int N_WIN_Y = DEF_MAP_H - DEF_K + 1;
   localparam int BEATS   = N_WIN_X * N_WIN_Y * DEF_K * DEF_K;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Counter width for a range of n values; never narrower than one bit
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/win_cnt_nest.sv
// Four-level window walk (c, r, wc, wr) with an incremental address
// accumulator: line base (wr), window base (wr,wc), row base (r), address (c).
module win_cnt_nest
   import conv_pkg::*;
#(
   parameter int MAP_W     = DEF_MAP_W,
   parameter int MAP_H     = DEF_MAP_H,
   parameter int K         = DEF_K,
   parameter int ADDR_STEP = DEF_ADDR_STEP,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int BASE      = DEF_BASE
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clear,
   input  logic              i_step,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_win_last,
   output logic              o_frame_last
);

   localparam int CW  = cnt_w(K);
   localparam int WCW = cnt_w(MAP_W - K + 1);
   localparam int WRW = cnt_w(MAP_H - K + 1);

   localparam logic [CW-1:0]     K_MAX  = CW'(K - 1);
   localparam logic [WCW-1:0]    WC_MAX = WCW'(MAP_W - K);
   localparam logic [WRW-1:0]    WR_MAX = WRW'(MAP_H - K);
   localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(ADDR_STEP);
   localparam logic [ADDR_W-1:0] ROW_A  = ADDR_W'(ADDR_STEP * MAP_W);
   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

   logic [CW-1:0]     c_q, c_d, r_q, r_d;
   logic [WCW-1:0]    wc_q, wc_d;
   logic [WRW-1:0]    wr_q, wr_d;
   logic [ADDR_W-1:0] line_q, line_d, win_q, win_d, row_q, row_d, addr_q, addr_d;
   logic              c_end, r_end, wc_end, wr_end;

   assign c_end  = (c_q == K_MAX);
   assign r_end  = (r_q == K_MAX);
   assign wc_end = (wc_q == WC_MAX);
   assign wr_end = (wr_q == WR_MAX);

   // Next-state of the nest: innermost counter carries into the outer ones,
   // each carry reloads the inner bases from the next-outer base.
   always_comb begin
      c_d    = c_q;
      r_d    = r_q;
      wc_d   = wc_q;
      wr_d   = wr_q;
      line_d = line_q;
      win_d  = win_q;
      row_d  = row_q;
      addr_d = addr_q;
      if (i_clear) begin
         c_d    = '0;
         r_d    = '0;
         wc_d   = '0;
         wr_d   = '0;
         line_d = BASE_A;
         win_d  = BASE_A;
         row_d  = BASE_A;
         addr_d = BASE_A;
      end else if (i_step) begin
         if (!c_end) begin
            c_d    = c_q + CW'(1);
            addr_d = addr_q + STEP_A;
         end else begin
            c_d = '0;
            if (!r_end) begin
               r_d    = r_q + CW'(1);
               row_d  = row_q + ROW_A;
               addr_d = row_q + ROW_A;
            end else begin
               r_d = '0;
               if (!wc_end) begin
                  wc_d   = wc_q + WCW'(1);
                  win_d  = win_q + STEP_A;
                  row_d  = win_q + STEP_A;
                  addr_d = win_q + STEP_A;
               end else begin
                  wc_d = '0;
                  if (!wr_end) begin
                     wr_d   = wr_q + WRW'(1);
                     line_d = line_q + ROW_A;
                     win_d  = line_q + ROW_A;
                     row_d  = line_q + ROW_A;
                     addr_d = line_q + ROW_A;
                  end else begin
                     wr_d   = '0;
                     line_d = BASE_A;
                     win_d  = BASE_A;
                     row_d  = BASE_A;
                     addr_d = BASE_A;
                  end
               end
            end
         end
      end
   end

   // Counter and accumulator registers
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         c_q    <= '0;
         r_q    <= '0;
         wc_q   <= '0;
         wr_q   <= '0;
         line_q <= BASE_A;
         win_q  <= BASE_A;
         row_q  <= BASE_A;
         addr_q <= BASE_A;
      end else begin
         c_q    <= c_d;
         r_q    <= r_d;
         wc_q   <= wc_d;
         wr_q   <= wr_d;
         line_q <= line_d;
         win_q  <= win_d;
         row_q  <= row_d;
         addr_q <= addr_d;
      end
   end

   assign o_addr       = addr_q;
   assign o_win_last   = c_end && r_end;
   assign o_frame_last = c_end && r_end && wc_end && wr_end;

endmodule

// File: rtl/conv2_window_rd_sched.sv
// Read scheduler feeding conv2_layer: walks every KxK window of the conv1 map,
// one buffer read per unstalled cycle, with valid/markers lagging by one cycle.
module conv2_window_rd_sched
   import conv_pkg::*;
#(
   parameter int MAP_W     = DEF_MAP_W,
   parameter int MAP_H     = DEF_MAP_H,
   parameter int K         = DEF_K,
   parameter int ADDR_STEP = DEF_ADDR_STEP,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int BASE      = DEF_BASE
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_stall,
   output logic              o_en,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_valid,
   output logic              o_win_last,
   output logic              o_frame_last,
   output logic              o_busy,
   output logic              o_done
);

   state_t            state_q;
   logic              en_q, mark_win_q, mark_frame_q;
   logic              valid_q, win_last_q, frame_last_q, busy_q, done_q;
   logic [ADDR_W-1:0] addr_q;

   logic              cnt_clear, cnt_step;
   logic [ADDR_W-1:0] cnt_addr;
   logic              cnt_win_last, cnt_frame_last;

   assign cnt_clear = (state_q == ST_IDLE) && i_start;
   assign cnt_step  = (state_q == ST_RUN) && !i_stall;

   win_cnt_nest #(
      .MAP_W     (MAP_W),
      .MAP_H     (MAP_H),
      .K         (K),
      .ADDR_STEP (ADDR_STEP),
      .ADDR_W    (ADDR_W),
      .BASE      (BASE)
   ) u_nest (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_clear      (cnt_clear),
      .i_step       (cnt_step),
      .o_addr       (cnt_addr),
      .o_win_last   (cnt_win_last),
      .o_frame_last (cnt_frame_last)
   );

   // Control FSM with registered issue outputs; busy covers RUN and DRAIN
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q      <= ST_IDLE;
         en_q         <= 1'b0;
         addr_q       <= '0;
         mark_win_q   <= 1'b0;
         mark_frame_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               en_q   <= 1'b0;
               done_q <= 1'b0;
               if (i_start) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (!i_stall) begin
                  en_q         <= 1'b1;
                  addr_q       <= cnt_addr;
                  mark_win_q   <= cnt_win_last;
                  mark_frame_q <= cnt_frame_last;
                  if (cnt_frame_last) begin
                     state_q <= ST_DRAIN;
                  end
               end else begin
                  en_q <= 1'b0;
               end
            end
            ST_DRAIN: begin
               en_q    <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Align valid and markers with the one-cycle buffer read latency
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         valid_q      <= 1'b0;
         win_last_q   <= 1'b0;
         frame_last_q <= 1'b0;
      end else begin
         valid_q      <= en_q;
         win_last_q   <= en_q && mark_win_q;
         frame_last_q <= en_q && mark_frame_q;
      end
   end

   assign o_en         = en_q;
   assign o_addr       = addr_q;
   assign o_valid      = valid_q;
   assign o_win_last   = win_last_q;
   assign o_frame_last = frame_last_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;

endmodule

// File: tb/tb_conv2_window_rd_sched.sv
// Scoreboard bench for conv2_window_rd_sched: expected window walk is pushed
// per accepted start; a negedge monitor pops and compares every issue.
module tb_conv2_window_rd_sched;

   localparam int MAP_W = 12;
   localparam int MAP_H = 12;
   localparam int K     = 5;
   localparam int STEP  = 6;
   localparam int NBEAT = (MAP_W - K + 1) * (MAP_H - K + 1) * K * K;
   localparam int NWIN  = (MAP_W - K + 1) * (MAP_H - K + 1);

   typedef struct packed {
      logic [9:0] addr;
      logic       wl;
      logic       fl;
   } exp_t;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b0;
   logic       i_start = 1'b0;
   logic       i_stall = 1'b0;
   logic       o_en, o_valid, o_win_last, o_frame_last, o_busy, o_done;
   logic [9:0] o_addr;

   conv2_window_rd_sched dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_start      (i_start),
      .i_stall      (i_stall),
      .o_en         (o_en),
      .o_addr       (o_addr),
      .o_valid      (o_valid),
      .o_win_last   (o_win_last),
      .o_frame_last (o_frame_last),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   always #5 i_clk = ~i_clk;

   int   n_checks = 0;
   int   n_pass = 0;
   exp_t exp_q[$];
   exp_t prev_exp = '0;
   exp_t cur_exp;
   bit   prev_en = 1'b0;
   logic stall_s = 1'b0;
   int   cyc = 0;
   int   last_en_cyc = 0;
   int   valid_cnt = 0;
   int   winlast_cnt = 0;
   int   done_cnt = 0;

   task automatic chk(input string name, input bit ok, input longint act, input longint req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
   endtask

   // Reference walk: every KxK window at stride 1, pixel address by formula
   task automatic push_frame();
      exp_t e;
      for (int wr = 0; wr <= MAP_H - K; wr++)
         for (int wc = 0; wc <= MAP_W - K; wc++)
            for (int r = 0; r < K; r++)
               for (int c = 0; c < K; c++) begin
                  e.addr = 10'(STEP * ((wr + r) * MAP_W + (wc + c)));
                  e.wl   = (r == K - 1) && (c == K - 1);
                  e.fl   = e.wl && (wr == MAP_H - K) && (wc == MAP_W - K);
                  exp_q.push_back(e);
               end
   endtask

   always @(posedge i_clk) stall_s <= i_stall;

   // Monitor: compares every DUT beat against the scoreboard
   always @(negedge i_clk) begin
      if (!i_rst) begin
         prev_en = 1'b0;
      end else begin
         cyc++;
         chk("valid_lag", o_valid == prev_en, o_valid, prev_en);
         if (o_valid) begin
            valid_cnt++;
            if (o_win_last) winlast_cnt++;
            chk("win_last", o_win_last == prev_exp.wl, o_win_last, prev_exp.wl);
            chk("frame_last", o_frame_last == prev_exp.fl, o_frame_last, prev_exp.fl);
         end else begin
            chk("markers_idle", !o_win_last && !o_frame_last, {o_win_last, o_frame_last}, 0);
         end
         if (stall_s) chk("stall_en", !o_en, o_en, 0);
         if (o_en) begin
            last_en_cyc = cyc;
            if (exp_q.size() == 0) begin
               chk("unexpected_issue", 1'b0, o_addr, -1);
            end else begin
               cur_exp = exp_q.pop_front();
               chk("addr", o_addr == cur_exp.addr, o_addr, cur_exp.addr);
               prev_exp = cur_exp;
            end
         end
         if (o_done) begin
            done_cnt++;
            chk("done_timing", cyc == last_en_cyc + 2, cyc - last_en_cyc, 2);
         end
         prev_en = o_en;
      end
   end

   task automatic do_frame(input int stall_pct, input bit repulse, input bit start_stall,
                           input bit bnd, input int rst_beat, input bit lat_chk);
      int b0, w0, d0, guard, hold;
      bit aborted, bnd_watch, bnd_used;
      b0 = valid_cnt; w0 = winlast_cnt; d0 = done_cnt;
      guard = 0; hold = 0; aborted = 0; bnd_watch = 0; bnd_used = 0;
      push_frame();
      @(negedge i_clk); #1;
      i_start = 1'b1; i_stall = start_stall;
      @(negedge i_clk); #1;
      i_start = 1'b0;
      chk("start_busy", o_busy == 1'b1 && o_en == 1'b0, {o_busy, o_en}, 2);
      if (lat_chk) begin
         i_stall = 1'b0;
         @(negedge i_clk); #1;
         chk("first_issue", o_en == 1'b1 && o_addr == 10'd0, {o_en, o_addr}, 1024);
      end
      while (done_cnt == d0 && guard < 20000) begin
         @(negedge i_clk); #1;
         guard++;
         if (rst_beat > 0 && valid_cnt - b0 >= rst_beat) begin
            i_rst = 1'b0;
            #1;
            chk("async_reset_outputs",
                {o_en, o_addr, o_valid, o_win_last, o_frame_last, o_busy, o_done} == 16'd0,
                {o_en, o_addr, o_valid, o_win_last, o_frame_last, o_busy, o_done}, 0);
            exp_q.delete();
            i_stall = 1'b0; i_start = 1'b0;
            repeat (3) @(negedge i_clk);
            #1 i_rst = 1'b1;
            repeat (3) @(negedge i_clk);
            chk("no_done_after_abort", done_cnt == d0, done_cnt - d0, 0);
            aborted = 1'b1;
            break;
         end
         if (bnd_watch && o_en) begin
            chk("bnd_next_addr", o_addr == 10'd6, o_addr, 6);
            bnd_watch = 1'b0;
         end
         if (hold > 0) begin
            hold--;
            i_stall = 1'b1;
         end else if (bnd && o_en && o_addr == 10'(24 + STEP * MAP_W * 4)) begin
            hold = 3;
            i_stall = 1'b1;
            if (!bnd_used) begin
               bnd_used = 1'b1;
               bnd_watch = 1'b1;
            end
         end else begin
            i_stall = ($urandom_range(99) < stall_pct);
         end
         i_start = repulse && o_busy && ($urandom_range(99) < 3);
      end
      i_start = 1'b0; i_stall = 1'b0;
      if (!aborted) begin
         chk("frame_timeout", guard < 20000, guard, 0);
         repeat (4) @(negedge i_clk);
         #1;
         chk("beats", valid_cnt - b0 == NBEAT, valid_cnt - b0, NBEAT);
         chk("win_last_count", winlast_cnt - w0 == NWIN, winlast_cnt - w0, NWIN);
         chk("done_once", done_cnt - d0 == 1, done_cnt - d0, 1);
         chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
         if (bnd) chk("bnd_stall_hit", bnd_used, bnd_used, 1);
      end
   endtask

   initial begin
      repeat (3) @(negedge i_clk);
      #1;
      chk("reset_state", {o_en, o_addr, o_valid, o_win_last, o_frame_last, o_busy, o_done} == 16'd0,
          {o_en, o_addr, o_valid, o_win_last, o_frame_last, o_busy, o_done}, 0);
      i_rst = 1'b1;
      repeat (2) @(negedge i_clk);
      do_frame(0, 1'b0, 1'b0, 1'b0, 0, 1'b1);     // clean frame, latency check
      do_frame(30, 1'b1, 1'b1, 1'b0, 0, 1'b0);    // random stall, start re-pulses
      do_frame(0, 1'b0, 1'b0, 1'b1, 0, 1'b0);     // stall across window boundary
      do_frame(0, 1'b0, 1'b0, 1'b0, 800, 1'b0);   // reset mid-frame
      do_frame(30, 1'b0, 1'b0, 1'b0, 0, 1'b0);    // full frame after restart
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/conv2_window_rd_sched.md
Name: conv2_window_rd_sched

Overview:
- Read-side scheduler for the intermediate feature-map buffer between the conv1 Max_relu stage and conv2_layer.
- After the conv1 map is fully written, it walks every KxK window of a MAP_H x MAP_W map at stride 1 and issues one buffer read per cycle.
- Outputs are the read enable, address, data-valid (aligned to the 1-cycle BRAM latency) and window/frame markers that drive conv2_layer i_valid.
- Handles downstream stall and signals frame completion so the write side can be released.

Parameters:
- MAP_W, 12, feature-map width in pixels
- MAP_H, 12, feature-map height in pixels
- K, 5, window edge length
- ADDR_STEP, 6, address increment per pixel (one 48-bit word = 3 x 16-bit channels)
- ADDR_W, 10, buffer address width
- BASE, 0, address of pixel (0,0)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-low reset
- i_start  in  1  pulse: conv1 map fully written
- i_stall  in  1  downstream not ready; hold issue
- o_en  out  1  buffer read enable (enb)
- o_addr  out  ADDR_W  buffer read address (addrb)
- o_valid  out  1  buffer doutb valid this cycle
- o_win_last  out  1  with o_valid: last pixel of current window
- o_frame_last  out  1  with o_valid: last pixel of last window
- o_busy  out  1  scheduler active (RUN or DRAIN)
- o_done  out  1  one-cycle pulse, frame finished

Behaviour:
- Reset is asynchronous active-low on i_rst. State goes to IDLE; all counters are 0. Outputs reset to: o_en=0, o_addr=0, o_valid=0, o_win_last=0, o_frame_last=0, o_busy=0, o_done=0.
- Counters: c (window column, 0..K-1) is innermost, then r (window row, 0..K-1), then wc (0..MAP_W-K), then wr (0..MAP_H-K).
- Counter widths use $clog2 of each range.
- Address = BASE + ADDR_STEP*((wr+r)*MAP_W + (wc+c)).
  - Computed incrementally with a row-base accumulator. No runtime multiplier.
  - Result is truncated to ADDR_W.
  - With defaults, the maximum address is 858.
- IDLE:
  - i_start=1 moves to RUN and clears the counters.
  - The first o_en=1 appears on the next edge with o_addr=BASE.
- RUN, at each edge:
  - If i_stall=0: o_en<=1, o_addr<=address(current counters), then the counters advance.
  - If i_stall=1: o_en<=0, and o_addr and the counters hold.
  - After the final element (wr=MAP_H-K, wc=MAP_W-K, r=c=K-1) is issued, go to DRAIN.
- DRAIN: o_en<=0 for one cycle, then go to DONE.
- DONE: o_done=1 for exactly one cycle, then return to IDLE. o_busy=0 in DONE.
- Output pipeline: o_valid, o_win_last and o_frame_last are registered copies of o_en and the issue-time markers. They lag o_en by exactly 1 cycle.
- Per frame: exactly (MAP_H-K+1)*(MAP_W-K+1)*K*K valid beats, which is 1600 with defaults.
- i_start while o_busy=1 or in DONE is ignored. No re-arm and no counter disturbance.
- Simultaneous i_start and i_stall in IDLE: go to RUN, but the first issue waits until i_stall=0.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0. No o_done. A new i_start restarts from BASE.
- Stall landing on a window boundary must not skip or duplicate addresses.

Decomposition:
- Shared package conv_pkg:
  - state encoding localparams ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE (2 bits)
  - derived constants N_WIN_X = MAP_W-K+1, N_WIN_Y = MAP_H-K+1, BEATS = N_WIN_X*N_WIN_Y*K*K
- One natural sub-module, win_cnt_nest:
  - the 4-level counter nest plus address accumulator, with step/advance input
  - outputs: address, is_win_last, is_frame_last
- The top holds the FSM and the output pipeline registers.

Test Plan:
- Reset then i_start pulse, i_stall=0.
  - o_en first asserts 1 cycle after start.
  - First 6 addresses: 0, 6, 12, 18, 24, 72.
  - o_valid trails o_en by 1 cycle.
- Full frame, no stall.
  - Exactly 1600 o_valid beats and 64 o_win_last pulses.
  - Window 1 starts at address 6; window 8 starts at 72.
  - Final address 858 carries o_frame_last=1.
  - o_done pulses once, 2 cycles after the last o_en.
- Random i_stall at about 30% duty.
  - The address sequence equals the no-stall sequence exactly.
  - o_en=0 in every stalled cycle.
  - Total beats remain 1600.
- Stall held across a window boundary: assert i_stall at the edge issuing 24+ADDR_STEP*MAP_W*4 for window 0's last element.
  - The next issued address after release is 6, with no duplicate.
- i_start re-pulsed mid-frame: no effect on the sequence and only one o_done.
- i_rst driven low at beat 800 then released, followed by i_start.
  - Outputs go to 0 asynchronously and o_done does not pulse.
  - The restart begins at address 0, and a full 1600-beat frame follows.
